frame_reader: RTL and testbench

Drains the edge-detect pipeline's output FIFO and turns the raw pixel stream into a framed valid/ready stream. It tracks column and row position and tags each pixel with start-of-frame, end-of-line and end-of-frame flags. At every frame boundary it produces a completion pulse, a frame count and a pixel checksum. It sits on the read side of the output FIFO, as the reader counterpart to the FIFO write handshake used throughout the image pipeline.

---
 rtl/frame_reader.sv | 141 ++++++++++++++
 tb/tb_frame_reader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// Reader side of the output pixel FIFO: pops pixels into a valid/ready output
// register, tags sof/eol/eof from the raster position and reports per-frame checksum.
module frame_reader #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  in_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic [31:0]           checksum
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [31:0]           sum_q, sum_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic                  done_q, done_d;
    logic [15:0]           count_q, count_d;
    logic [31:0]           chk_q, chk_d;

    logic pop, accept, last_col, last_row;

    // The output register may refill on the same edge it is drained, giving full throughput.
    assign pop      = (state_q == RUN) && !in_empty && (!valid_q || out_ready);
    assign accept   = valid_q && out_ready;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    assign in_rd_en    = pop && reset;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_sof     = sof_q;
    assign out_eol     = eol_q;
    assign out_eof     = eof_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;
    assign checksum    = chk_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        data_d  = data_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        done_d  = 1'b0;
        count_d = count_q;
        chk_d   = chk_q;

        if (pop) begin
            valid_d = 1'b1;
            data_d  = in_dout;
            sof_d   = (col_q == '0) && (row_q == '0);
            eol_d   = last_col;
            eof_d   = last_col && last_row;
            sum_d   = sum_q + 32'(in_dout);
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (pop && last_col && last_row) state_d = FLUSH;
            end
            FLUSH: begin
                // Only the eof pixel can be pending here, so its acceptance closes the frame.
                if (accept) begin
                    done_d  = 1'b1;
                    chk_d   = sum_q;
                    sum_d   = '0;
                    count_d = count_q + 16'd1;
                    state_d = enable ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
            count_q <= count_d;
            chk_q   <= chk_d;
        end
    end
endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: a 4x2 instance for framing/handshake scenarios and a
// 64x32 instance of all-ones pixels for back-to-back frames with checksum wrap.
module tb_frame_reader;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int BW = 64;
    localparam int BH = 32;
    localparam int BN = BW * BH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- small instance ----------------
    logic        s_en = 1'b0, s_ready = 1'b0;
    logic        s_empty, s_rd, s_valid, s_sof, s_eol, s_eof, s_done;
    logic [23:0] s_dout, s_data;
    logic [15:0] s_cnt;
    logic [31:0] s_chk;
    logic [23:0] smem [0:255];
    int          s_wp = 0, s_rp = 0;

    assign s_empty = (s_rp == s_wp);
    assign s_dout  = smem[s_rp % 256];
    always @(posedge clk) if (s_rd) s_rp <= s_rp + 1;

    frame_reader #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(24)) u_small (
        .clock(clk), .reset(rst_n), .enable(s_en), .in_empty(s_empty), .in_dout(s_dout),
        .in_rd_en(s_rd), .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
        .out_sof(s_sof), .out_eol(s_eol), .out_eof(s_eof), .frame_done(s_done),
        .frame_count(s_cnt), .checksum(s_chk)
    );

    // ---------------- large instance ----------------
    logic        b_en = 1'b0, b_ready = 1'b0;
    logic        b_empty, b_rd, b_valid, b_sof, b_eol, b_eof, b_done;
    logic [23:0] b_dout, b_data;
    logic [15:0] b_cnt;
    logic [31:0] b_chk;
    logic [23:0] bmem [0:8191];
    int          b_wp = 0, b_rp = 0;

    assign b_empty = (b_rp == b_wp);
    assign b_dout  = bmem[b_rp % 8192];
    always @(posedge clk) if (b_rd) b_rp <= b_rp + 1;

    frame_reader #(.WIDTH(BW), .HEIGHT(BH), .DATA_WIDTH(24)) u_big (
        .clock(clk), .reset(rst_n), .enable(b_en), .in_empty(b_empty), .in_dout(b_dout),
        .in_rd_en(b_rd), .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_sof(b_sof), .out_eol(b_eol), .out_eof(b_eof), .frame_done(b_done),
        .frame_count(b_cnt), .checksum(b_chk)
    );

    // ---------------- monitors (sampled mid-cycle) ----------------
    logic [23:0] ref_q [$];
    logic [23:0] acc_d [$];
    logic [2:0]  acc_f [$];
    int          acc_c [$];
    int          done_cnt = 0;
    int          unstable = 0;
    logic        s_pend = 1'b0;
    logic [23:0] s_pd;
    logic [2:0]  s_pf;

    int          b_pop_c [$];
    logic [31:0] b_chk_q [$];
    int          b_done_cnt = 0;
    int          b_acc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_pend && (!s_valid || s_data !== s_pd || {s_sof, s_eol, s_eof} !== s_pf))
                unstable++;
            s_pend = s_valid && !s_ready;
            s_pd   = s_data;
            s_pf   = {s_sof, s_eol, s_eof};
            if (s_valid && s_ready) begin
                acc_d.push_back(s_data);
                acc_f.push_back({s_sof, s_eol, s_eof});
                acc_c.push_back(cyc);
            end
            if (s_done) done_cnt++;
            if (b_rd) b_pop_c.push_back(cyc);
            if (b_valid && b_ready) b_acc++;
            if (b_done) begin
                b_done_cnt++;
                b_chk_q.push_back(b_chk);
            end
        end else begin
            s_pend = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] v);
        smem[s_wp % 256] = v;
        ref_q.push_back(v);
        s_wp++;
    endtask

    function automatic logic [2:0] exp_flags(input int k, input int w, input int h);
        int p;
        p = k % (w * h);
        return {p == 0, (p % w) == w - 1, p == w * h - 1};
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        s_en    = 1'b0;
        s_ready = 1'b0;
        b_en    = 1'b0;
        b_ready = 1'b0;
        tick();
        s_wp = s_rp;
        b_wp = b_rp;
        ref_q.delete(); acc_d.delete(); acc_f.delete(); acc_c.delete();
        b_pop_c.delete(); b_chk_q.delete();
        done_cnt = 0; unstable = 0; b_done_cnt = 0; b_acc = 0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        int t = 0;
        while (acc_d.size() < n && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (acc_d.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d pixels, need %0d", tag, acc_d.size(), n);
        end
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int t = 0;
        while (done_cnt < n && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (done_cnt < n) begin
            errors++;
            $display("FAIL %s done timeout: got %0d pulses, need %0d", tag, done_cnt, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({s_valid, s_sof, s_eol, s_eof, s_done, s_rd} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 000000", {s_valid, s_sof, s_eol, s_eof, s_done, s_rd});
        end
        checks++;
        if (s_data !== 24'd0 || s_cnt !== 16'd0 || s_chk !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h cnt=%0d chk=%h, want zeros", s_data, s_cnt, s_chk);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int sum = 0;
        do_reset();
        for (int k = 1; k <= 8; k++) push(24'(k));
        s_en = 1'b1;
        s_ready = 1'b1;
        wait_acc(8, 50, "basic");
        wait_done(1, 10, "basic");
        repeat (3) tick();
        for (int k = 0; k < 8 && k < acc_d.size(); k++) begin
            sum += int'(ref_q[k]);
            checks++;
            if (acc_d[k] !== ref_q[k] || acc_f[k] !== exp_flags(k, W, H)) begin
                errors++;
                $display("FAIL basic_px%0d: data=%0d flags=%b, want data=%0d flags=%b",
                         k, acc_d[k], acc_f[k], ref_q[k], exp_flags(k, W, H));
            end
        end
        checks++;
        if (acc_c.size() == 8 && acc_c[7] - acc_c[0] != 7) begin
            errors++;
            $display("FAIL basic_throughput: span=%0d cycles, want 7", acc_c[7] - acc_c[0]);
        end
        checks++;
        if (done_cnt != 1 || s_chk !== 32'(sum) || s_cnt !== 16'd1) begin
            errors++;
            $display("FAIL basic_frame: done=%0d chk=%0d cnt=%0d, want done=1 chk=%0d cnt=1",
                     done_cnt, s_chk, s_cnt, sum);
        end
    endtask

    task automatic test_backpressure();
        longint sum1 = 0, sum2 = 0;
        int t = 0;
        do_reset();
        for (int k = 1; k <= 8; k++) push(24'(k));
        for (int k = 0; k < 8; k++) push(24'($urandom));
        for (int k = 0; k < 8; k++) sum1 += longint'(ref_q[k]);
        for (int k = 8; k < 16; k++) sum2 += longint'(ref_q[k]);
        s_en = 1'b1;
        while (acc_d.size() < 16 && t < 400) begin
            s_ready = (acc_d.size() < 8) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
            tick();
            t++;
            if (done_cnt == 1 && acc_d.size() == 8) begin
                checks++;
                if (s_chk !== 32'(sum1)) begin
                    errors++;
                    $display("FAIL bp_chk1: got %0d, want %0d", s_chk, 32'(sum1));
                end
            end
        end
        s_ready = 1'b1;
        wait_acc(16, 20, "backpressure");
        wait_done(2, 20, "backpressure");
        tick();
        for (int k = 0; k < 16 && k < acc_d.size(); k++) begin
            checks++;
            if (acc_d[k] !== ref_q[k] || acc_f[k] !== exp_flags(k, W, H)) begin
                errors++;
                $display("FAIL bp_px%0d: data=%h flags=%b, want data=%h flags=%b",
                         k, acc_d[k], acc_f[k], ref_q[k], exp_flags(k, W, H));
            end
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d changes while stalled, want 0", unstable);
        end
        checks++;
        if (s_chk !== 32'(sum2) || s_cnt !== 16'd2 || done_cnt != 2) begin
            errors++;
            $display("FAIL bp_frame2: chk=%h cnt=%0d done=%0d, want chk=%h cnt=2 done=2",
                     s_chk, s_cnt, done_cnt, 32'(sum2));
        end
    endtask

    task automatic test_gap();
        do_reset();
        for (int k = 1; k <= 3; k++) push(24'(k));
        s_en = 1'b1;
        s_ready = 1'b1;
        wait_acc(3, 20, "gap_pre");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_rd !== 1'b0) begin
                errors++;
                $display("FAIL gap_rd%0d: in_rd_en=%b, want 0", i, s_rd);
            end
            tick();
        end
        for (int k = 4; k <= 8; k++) push(24'(k));
        wait_acc(8, 30, "gap_post");
        wait_done(1, 10, "gap");
        tick();
        checks++;
        if (acc_d.size() == 8 && (acc_d[3] !== 24'd4 || acc_f[3] !== 3'b010)) begin
            errors++;
            $display("FAIL gap_px4: data=%0d flags=%b, want data=4 flags=010", acc_d[3], acc_f[3]);
        end
        checks++;
        if (s_chk !== 32'd36) begin
            errors++;
            $display("FAIL gap_chk: got %0d, want 36", s_chk);
        end
    endtask

    task automatic test_enable_drop();
        longint sum = 0;
        do_reset();
        for (int k = 0; k < 16; k++) push(24'($urandom));
        for (int k = 0; k < 8; k++) sum += longint'(ref_q[k]);
        s_en = 1'b1;
        s_ready = 1'b1;
        wait_acc(2, 20, "en_drop");
        s_en = 1'b0;
        wait_done(1, 30, "en_drop");
        repeat (10) tick();
        checks++;
        if (acc_d.size() != 8 || (s_wp - s_rp) != 8) begin
            errors++;
            $display("FAIL en_drop_pops: accepted=%0d left=%0d, want accepted=8 left=8",
                     acc_d.size(), s_wp - s_rp);
        end
        checks++;
        if (s_cnt !== 16'd1 || done_cnt != 1 || s_chk !== 32'(sum)) begin
            errors++;
            $display("FAIL en_drop_frame: cnt=%0d done=%0d chk=%h, want cnt=1 done=1 chk=%h",
                     s_cnt, done_cnt, s_chk, 32'(sum));
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] exp;
        do_reset();
        for (int k = 1; k <= 16; k++) push(24'(k));
        s_en = 1'b1;
        s_ready = 1'b1;
        wait_acc(4, 20, "rst_mid");
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_valid, s_sof, s_eol, s_eof, s_done, s_rd} !== 6'b0 || s_data !== 24'd0
            || s_cnt !== 16'd0 || s_chk !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: valid=%b data=%h flags=%b rd=%b cnt=%0d chk=%h, want all 0",
                     s_valid, s_data, {s_sof, s_eol, s_eof}, s_rd, s_cnt, s_chk);
        end
        repeat (2) tick();
        exp = smem[s_rp % 256];
        acc_d.delete(); acc_f.delete(); acc_c.delete();
        rst_n = 1'b1;
        wait_acc(1, 20, "rst_mid_restart");
        checks++;
        if (acc_d.size() > 0 && (acc_d[0] !== exp || acc_f[0] !== 3'b100)) begin
            errors++;
            $display("FAIL rst_mid_restart: data=%0d flags=%b, want data=%0d flags=100",
                     acc_d[0], acc_f[0], exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_chk;
        int t = 0;
        do_reset();
        for (int k = 0; k < 2 * BN; k++) bmem[k % 8192] = 24'hFFFFFF;
        b_wp = b_rp + 2 * BN;
        exp_chk = 32'((longint'(24'hFFFFFF) * BN) % 64'h1_0000_0000);
        b_en = 1'b1;
        b_ready = 1'b1;
        while (b_done_cnt < 2 && t < 10000) begin
            tick();
            t++;
        end
        tick();
        checks++;
        if (b_done_cnt != 2 || b_cnt !== 16'd2 || b_acc != 2 * BN) begin
            errors++;
            $display("FAIL b2b_frames: done=%0d cnt=%0d accepted=%0d, want 2 2 %0d",
                     b_done_cnt, b_cnt, b_acc, 2 * BN);
        end
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (b_chk_q.size() <= f || b_chk_q[f] !== exp_chk) begin
                errors++;
                $display("FAIL b2b_chk%0d: got %h, want %h", f,
                         (b_chk_q.size() > f) ? b_chk_q[f] : 32'hx, exp_chk);
            end
        end
        checks++;
        if (b_pop_c.size() != 2 * BN) begin
            errors++;
            $display("FAIL b2b_pops: got %0d, want %0d", b_pop_c.size(), 2 * BN);
        end else if (b_pop_c[BN] - b_pop_c[BN - 1] != 2 || b_pop_c[2 * BN - 1] - b_pop_c[0] != 2 * BN) begin
            errors++;
            $display("FAIL b2b_gap: boundary step=%0d span=%0d, want step=2 span=%0d",
                     b_pop_c[BN] - b_pop_c[BN - 1], b_pop_c[2 * BN - 1] - b_pop_c[0], 2 * BN);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
